mem_arbiter: RTL and testbench

Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch requester and its load/store requester. Each accepted request is latched, driven to memory until acknowledged, and returned to its owner as a one-cycle response pulse. Data accesses normally win, and a starvation counter guarantees forward progress for fetch. The block sits between the PC/fetch and memory stages and the external memory model. Its stall outputs feed the pipeline's hazard logic.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_if.sv | 63 ++++++
 rtl/mem_arb_pick.sv | 54 +++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter slice. It holds the following:
//   - the FSM state encoding
//   - the owner codes, which also index the grant vector
//   - the byte-lane mask width
//   - a helper that maps an owner onto its busy state
package mem_arbiter_pkg;

  localparam int MA_MASK_W = 4;
  localparam int MA_GNT_W  = 2;

  typedef enum logic [1:0] {
    MA_IDLE    = 2'd0,
    MA_BUSY_IF = 2'd1,
    MA_BUSY_DM = 2'd2
  } ma_state_e;

  // Owner codes double as bit positions in the grant vector.
  typedef enum logic {
    MA_OWN_IF = 1'b0,
    MA_OWN_DM = 1'b1
  } ma_owner_e;

  function automatic ma_state_e ma_busy_state(input ma_owner_e owner);
    ma_state_e st_s;
    case (owner)
      MA_OWN_IF: st_s = MA_BUSY_IF;
      MA_OWN_DM: st_s = MA_BUSY_DM;
      default:   st_s = MA_IDLE;
    endcase
    return st_s;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the arbiter's three buses:
//   - fetch requester
//   - load/store requester
//   - unified memory
//
//   The master modport is the arbiter's own view. It drives the grants, the
//   responses, the stalls and the memory request. The slave modport is the
//   environment's view: the pipeline stages together with the memory model.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);

  // fetch requester
  logic                 ma_i_if_req;
  logic [AWIDTH-1:0]    ma_i_if_addr;
  logic                 ma_o_if_gnt;
  logic                 ma_o_if_valid;
  logic [DWIDTH-1:0]    ma_o_if_rdata;
  logic                 ma_o_if_stall;

  // load/store requester
  logic                 ma_i_dm_req;
  logic                 ma_i_dm_we;
  logic [MA_MASK_W-1:0] ma_i_dm_mask;
  logic [AWIDTH-1:0]    ma_i_dm_addr;
  logic [DWIDTH-1:0]    ma_i_dm_wdata;
  logic                 ma_o_dm_gnt;
  logic                 ma_o_dm_valid;
  logic [DWIDTH-1:0]    ma_o_dm_rdata;
  logic                 ma_o_dm_stall;

  // unified memory
  logic                 ma_o_mem_req;
  logic                 ma_o_mem_we;
  logic [MA_MASK_W-1:0] ma_o_mem_mask;
  logic [AWIDTH-1:0]    ma_o_mem_addr;
  logic [DWIDTH-1:0]    ma_o_mem_wdata;
  logic                 ma_i_mem_ack;
  logic [DWIDTH-1:0]    ma_i_mem_rdata;

  modport master (
    input  ma_i_if_req, ma_i_if_addr,
    output ma_o_if_gnt, ma_o_if_valid, ma_o_if_rdata, ma_o_if_stall,
    input  ma_i_dm_req, ma_i_dm_we, ma_i_dm_mask, ma_i_dm_addr, ma_i_dm_wdata,
    output ma_o_dm_gnt, ma_o_dm_valid, ma_o_dm_rdata, ma_o_dm_stall,
    output ma_o_mem_req, ma_o_mem_we, ma_o_mem_mask, ma_o_mem_addr, ma_o_mem_wdata,
    input  ma_i_mem_ack, ma_i_mem_rdata
  );

  modport slave (
    output ma_i_if_req, ma_i_if_addr,
    input  ma_o_if_gnt, ma_o_if_valid, ma_o_if_rdata, ma_o_if_stall,
    output ma_i_dm_req, ma_i_dm_we, ma_i_dm_mask, ma_i_dm_addr, ma_i_dm_wdata,
    input  ma_o_dm_gnt, ma_o_dm_valid, ma_o_dm_rdata, ma_o_dm_stall,
    input  ma_o_mem_req, ma_o_mem_we, ma_o_mem_mask, ma_o_mem_addr, ma_o_mem_wdata,
    output ma_i_mem_ack, ma_i_mem_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational winner selection between fetch and data requests.
//
//   Inputs:
//   - if_req, dm_req : request lines
//   - starve_cnt     : current count of fetch losses
//   - starve_limit   : the loss count at which fetch is forced to win
//
//   Outputs:
//   - gnt            : one-hot grant, indexed by ma_owner_e
//   - starve_cnt_nxt : the counter value if this grant is taken
//
//   There is no state in this block. The caller decides whether the result is
//   used, which only happens when the arbiter is idle.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic                if_req,
  input  logic                dm_req,
  input  logic [CNT_W-1:0]    starve_cnt,
  input  logic [CNT_W-1:0]    starve_limit,
  output logic [MA_GNT_W-1:0] gnt,
  output logic [CNT_W-1:0]    starve_cnt_nxt
);

  // winner and starvation-counter update
  always_comb begin
    gnt            = {MA_GNT_W{1'b0}};
    starve_cnt_nxt = starve_cnt;
    if (if_req && dm_req) begin
      // ">=" keeps a corrupted counter from letting data win forever.
      if (starve_cnt >= starve_limit) begin
        gnt[MA_OWN_IF] = 1'b1;
        starve_cnt_nxt = {CNT_W{1'b0}};
      end else begin
        gnt[MA_OWN_DM] = 1'b1;
        // Below the limit, so +1 saturates exactly at starve_limit.
        starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
    end else if (if_req) begin
      gnt[MA_OWN_IF] = 1'b1;
      starve_cnt_nxt = {CNT_W{1'b0}};
    end else if (dm_req) begin
      gnt[MA_OWN_DM] = 1'b1;
      starve_cnt_nxt = starve_cnt;
    end else begin
      gnt            = {MA_GNT_W{1'b0}};
      starve_cnt_nxt = starve_cnt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported, variable-latency memory between instruction
//   fetch and load/store. At most one transaction is outstanding at a time.
//
//   Flow of a transaction:
//   - The request is latched in IDLE.
//   - It is driven to memory until ack.
//   - It is returned to its owner as a one-cycle valid pulse.
//
//   Ports:
//   - ma_clk, ma_rst : clock, and synchronous active-high reset
//   - bus (master)   : carries the following groups
//       - fetch req/addr/gnt/valid/rdata/stall
//       - data req/we/mask/addr/wdata/gnt/valid/rdata/stall
//       - memory req/we/mask/addr/wdata/ack/rdata
//
//   Grant and stall outputs are combinational. All other outputs are
//   registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          ma_clk,
  input  logic          ma_rst,
  mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  ma_state_e            state_r;
  logic [CNT_W-1:0]     starve_cnt_r;
  logic                 mem_req_r;
  logic                 mem_we_r;
  logic [MA_MASK_W-1:0] mem_mask_r;
  logic [AWIDTH-1:0]    mem_addr_r;
  logic [DWIDTH-1:0]    mem_wdata_r;
  logic                 if_valid_r;
  logic [DWIDTH-1:0]    if_rdata_r;
  logic                 dm_valid_r;
  logic [DWIDTH-1:0]    dm_rdata_r;

  logic [MA_GNT_W-1:0]  pick_gnt_s;
  logic [CNT_W-1:0]     pick_cnt_s;
  logic                 idle_s;
  logic                 if_gnt_s;
  logic                 dm_gnt_s;
  ma_owner_e            win_owner_s;

  mem_arb_pick #(
    .CNT_W (CNT_W)
  ) u_pick (
    .if_req         (bus.ma_i_if_req),
    .dm_req         (bus.ma_i_dm_req),
    .starve_cnt     (starve_cnt_r),
    .starve_limit   (LIMIT_C),
    .gnt            (pick_gnt_s),
    .starve_cnt_nxt (pick_cnt_s)
  );

  // A grant is only offered while idle and out of reset.
  assign idle_s      = (state_r == MA_IDLE) & ~ma_rst;
  assign if_gnt_s    = idle_s & pick_gnt_s[MA_OWN_IF];
  assign dm_gnt_s    = idle_s & pick_gnt_s[MA_OWN_DM];
  assign win_owner_s = dm_gnt_s ? MA_OWN_DM : MA_OWN_IF;

  // FSM with request latch, starvation counter and response registers.
  always_ff @(posedge ma_clk) begin
    if (ma_rst) begin
      state_r      <= MA_IDLE;
      starve_cnt_r <= {CNT_W{1'b0}};
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_mask_r   <= {MA_MASK_W{1'b0}};
      mem_addr_r   <= {AWIDTH{1'b0}};
      mem_wdata_r  <= {DWIDTH{1'b0}};
      if_valid_r   <= 1'b0;
      if_rdata_r   <= {DWIDTH{1'b0}};
      dm_valid_r   <= 1'b0;
      dm_rdata_r   <= {DWIDTH{1'b0}};
    end else begin
      // Valids are single-cycle pulses.
      if_valid_r <= 1'b0;
      dm_valid_r <= 1'b0;
      case (state_r)
        MA_IDLE: begin
          // A stray ack while idle falls through here untouched.
          if (if_gnt_s || dm_gnt_s) begin
            starve_cnt_r <= pick_cnt_s;
            mem_req_r    <= 1'b1;
            state_r      <= ma_busy_state(win_owner_s);
            if (dm_gnt_s) begin
              mem_we_r    <= bus.ma_i_dm_we;
              mem_mask_r  <= bus.ma_i_dm_mask;
              mem_addr_r  <= bus.ma_i_dm_addr;
              mem_wdata_r <= bus.ma_i_dm_wdata;
            end else begin
              mem_we_r    <= 1'b0;
              mem_mask_r  <= {MA_MASK_W{1'b0}};
              mem_addr_r  <= bus.ma_i_if_addr;
              mem_wdata_r <= {DWIDTH{1'b0}};
            end
          end else begin
            state_r <= MA_IDLE;
          end
        end
        MA_BUSY_IF: begin
          if (bus.ma_i_mem_ack) begin
            if_rdata_r <= bus.ma_i_mem_rdata;
            if_valid_r <= 1'b1;
            mem_req_r  <= 1'b0;
            state_r    <= MA_IDLE;
          end else begin
            state_r <= MA_BUSY_IF;
          end
        end
        MA_BUSY_DM: begin
          if (bus.ma_i_mem_ack) begin
            // A store completes with zero read data.
            dm_rdata_r <= mem_we_r ? {DWIDTH{1'b0}} : bus.ma_i_mem_rdata;
            dm_valid_r <= 1'b1;
            mem_req_r  <= 1'b0;
            state_r    <= MA_IDLE;
          end else begin
            state_r <= MA_BUSY_DM;
          end
        end
        default: begin
          // Recovery from an illegal encoding: drop any request and idle.
          mem_req_r <= 1'b0;
          state_r   <= MA_IDLE;
        end
      endcase
    end
  end

  assign bus.ma_o_if_gnt    = if_gnt_s;
  assign bus.ma_o_dm_gnt    = dm_gnt_s;
  assign bus.ma_o_if_valid  = if_valid_r;
  assign bus.ma_o_if_rdata  = if_rdata_r;
  assign bus.ma_o_dm_valid  = dm_valid_r;
  assign bus.ma_o_dm_rdata  = dm_rdata_r;
  assign bus.ma_o_mem_req   = mem_req_r;
  assign bus.ma_o_mem_we    = mem_we_r;
  assign bus.ma_o_mem_mask  = mem_mask_r;
  assign bus.ma_o_mem_addr  = mem_addr_r;
  assign bus.ma_o_mem_wdata = mem_wdata_r;

  // Stall while a request waits for a grant or the owner's transaction is in
  // flight. The valid cycle itself is already back in IDLE.
  assign bus.ma_o_if_stall = ~ma_rst &
                             ((bus.ma_i_if_req & ~if_gnt_s) | (state_r == MA_BUSY_IF));
  assign bus.ma_o_dm_stall = ~ma_rst &
                             ((bus.ma_i_dm_req & ~dm_gnt_s) | (state_r == MA_BUSY_DM));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A small memory model answers mem_req
//   after a programmable latency, returning mem_word(addr). Expected responses
//   are queued as grants are stimulated. A monitor pops and compares them on
//   every valid pulse.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic ma_clk;
  logic ma_rst;

  int checks;
  int errors;

  // memory-model controls
  int   mem_lat;
  logic mem_en;
  logic manual_ack;

  typedef struct packed {
    logic        dm;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  mem_arbiter #(
    .AWIDTH       (32),
    .DWIDTH       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .ma_clk (ma_clk),
    .ma_rst (ma_rst),
    .bus    (bus)
  );

  initial begin
    ma_clk = 1'b0;
    forever #5 ma_clk = ~ma_clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h2002_004A;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // advance to just after the next rising edge (input drive point)
  task automatic cyc();
    @(posedge ma_clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {56'd0, bus.ma_o_if_gnt, bus.ma_o_dm_gnt, bus.ma_o_if_valid,
                          bus.ma_o_dm_valid, bus.ma_o_if_stall, bus.ma_o_dm_stall,
                          bus.ma_o_mem_req, bus.ma_o_mem_we}, 64'd0);
    check({tag, "_mask"}, {60'd0, bus.ma_o_mem_mask}, 64'd0);
    check({tag, "_addr"}, {32'd0, bus.ma_o_mem_addr}, 64'd0);
    check({tag, "_wdata"}, {32'd0, bus.ma_o_mem_wdata}, 64'd0);
    check({tag, "_rdata"}, {bus.ma_o_if_rdata, bus.ma_o_dm_rdata}, 64'd0);
  endtask

  // memory model: acks after mem_lat cycles of mem_req, or on manual_ack when disabled
  initial begin : mem_model
    int cnt;
    cnt = 0;
    bus.ma_i_mem_ack   = 1'b0;
    bus.ma_i_mem_rdata = 32'h0;
    forever begin
      @(posedge ma_clk);
      #2;
      bus.ma_i_mem_ack = 1'b0;
      if (!mem_en) begin
        cnt = 0;
        if (manual_ack) begin
          bus.ma_i_mem_ack   = 1'b1;
          bus.ma_i_mem_rdata = mem_word(bus.ma_o_mem_addr);
        end
      end else if (ma_rst || !bus.ma_o_mem_req) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          bus.ma_i_mem_ack   = 1'b1;
          bus.ma_i_mem_rdata = mem_word(bus.ma_o_mem_addr);
          cnt = 0;
        end
      end
    end
  end

  // scoreboard monitor: every valid pulse must match the oldest queued response
  initial begin : sb_monitor
    sb_t e;
    forever begin
      @(negedge ma_clk);
      if (bus.ma_o_if_valid || bus.ma_o_dm_valid) begin
        check("sb_one_valid", {63'd0, bus.ma_o_if_valid & bus.ma_o_dm_valid}, 64'd0);
        if (sb.size() == 0) begin
          check("sb_unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_owner", {63'd0, bus.ma_o_dm_valid}, {63'd0, e.dm});
          check("sb_data", {32'd0, bus.ma_o_dm_valid ? bus.ma_o_dm_rdata : bus.ma_o_if_rdata},
                {32'd0, e.data});
        end
      end
    end
  end

  initial begin : main
    logic [9:0]  if_turn;
    logic [31:0] if_a;
    logic [31:0] dm_a;
    logic        exp_if;
    checks     = 0;
    errors     = 0;
    mem_lat    = 1;
    mem_en     = 1'b1;
    manual_ack = 1'b0;

    // ---------- reset with both requests high ----------
    ma_rst            = 1'b1;
    bus.ma_i_if_req   = 1'b1;
    bus.ma_i_if_addr  = 32'h0000_0080;
    bus.ma_i_dm_req   = 1'b1;
    bus.ma_i_dm_we    = 1'b0;
    bus.ma_i_dm_mask  = 4'hF;
    bus.ma_i_dm_addr  = 32'h0000_0200;
    bus.ma_i_dm_wdata = 32'h5555_AAAA;
    repeat (3) begin
      cyc();
      @(negedge ma_clk);
      check_quiet("reset");
    end
    cyc();
    ma_rst = 1'b0;
    @(negedge ma_clk);
    check("rel_dm_gnt", {63'd0, bus.ma_o_dm_gnt}, 64'd1);
    check("rel_if_gnt", {63'd0, bus.ma_o_if_gnt}, 64'd0);
    check("rel_if_stall", {63'd0, bus.ma_o_if_stall}, 64'd1);
    sb.push_back('{dm: 1'b1, data: mem_word(32'h0000_0200)});
    cyc();
    bus.ma_i_if_req = 1'b0;
    bus.ma_i_dm_req = 1'b0;
    @(negedge ma_clk);
    check("rel_mem_req", {63'd0, bus.ma_o_mem_req}, 64'd1);
    check("rel_mem_addr", {32'd0, bus.ma_o_mem_addr}, 64'h200);
    check("rel_dm_stall", {63'd0, bus.ma_o_dm_stall}, 64'd1);
    cyc();
    @(negedge ma_clk);
    check("rel_dm_valid", {63'd0, bus.ma_o_dm_valid}, 64'd1);

    // ---------- single fetch, ack on the third cycle of mem_req ----------
    cyc();
    mem_lat          = 3;
    bus.ma_i_if_req  = 1'b1;
    bus.ma_i_if_addr = 32'h0000_0040;
    @(negedge ma_clk);
    check("if_gnt_c0", {63'd0, bus.ma_o_if_gnt}, 64'd1);
    check("if_mem_req_c0", {63'd0, bus.ma_o_mem_req}, 64'd0);
    sb.push_back('{dm: 1'b0, data: 32'h2002_000A});
    cyc();
    bus.ma_i_if_req  = 1'b0;
    bus.ma_i_if_addr = 32'hDEAD_0000;
    @(negedge ma_clk);
    check("if_mem_fields", {bus.ma_o_mem_addr, 27'd0, bus.ma_o_mem_we, bus.ma_o_mem_mask},
          {32'h0000_0040, 32'd0});
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) begin
        cyc();
        @(negedge ma_clk);
      end
      check($sformatf("if_busy_c%0d", c),
            {61'd0, bus.ma_o_mem_req, bus.ma_o_if_valid, bus.ma_o_if_stall}, 64'b101);
    end
    cyc();
    @(negedge ma_clk);
    check("if_valid_c4", {61'd0, bus.ma_o_if_valid, bus.ma_o_mem_req, bus.ma_o_if_stall}, 64'b100);
    check("if_rdata_c4", {32'd0, bus.ma_o_if_rdata}, 64'h2002_000A);
    cyc();
    @(negedge ma_clk);
    check("if_valid_c5", {63'd0, bus.ma_o_if_valid}, 64'd0);

    // ---------- contention: grant order D,D,D,D,I,D,D,D,D,I ----------
    mem_lat = 1;
    if_turn = 10'b10_0001_0000;
    if_a    = 32'h0000_1000;
    dm_a    = 32'h0000_2000;
    cyc();
    bus.ma_i_if_req  = 1'b1;
    bus.ma_i_if_addr = if_a;
    bus.ma_i_dm_req  = 1'b1;
    bus.ma_i_dm_we   = 1'b0;
    bus.ma_i_dm_addr = dm_a;
    for (int g = 0; g < 10; g++) begin
      exp_if = if_turn[g];
      @(negedge ma_clk);
      check($sformatf("cont_gnt_%0d", g), {62'd0, bus.ma_o_if_gnt, bus.ma_o_dm_gnt},
            {62'd0, exp_if, ~exp_if});
      check($sformatf("cont_loser_stall_%0d", g),
            {63'd0, exp_if ? bus.ma_o_dm_stall : bus.ma_o_if_stall}, 64'd1);
      sb.push_back('{dm: ~exp_if, data: mem_word(exp_if ? if_a : dm_a)});
      cyc();
      if (exp_if) begin
        if_a = if_a + 32'd4;
        bus.ma_i_if_addr = if_a;
      end else begin
        dm_a = dm_a + 32'd4;
        bus.ma_i_dm_addr = dm_a;
      end
      if (g == 9) begin
        bus.ma_i_if_req = 1'b0;
        bus.ma_i_dm_req = 1'b0;
      end
      @(negedge ma_clk);
      check($sformatf("cont_busy_%0d", g),
            {61'd0, bus.ma_o_if_gnt, bus.ma_o_dm_gnt, bus.ma_o_mem_req}, 64'b001);
      if (g < 9) begin
        check($sformatf("cont_stalls_%0d", g), {62'd0, bus.ma_o_if_stall, bus.ma_o_dm_stall},
              64'b11);
      end
      cyc();
    end
    @(negedge ma_clk);
    cyc();

    // ---------- store with a two-cycle memory ----------
    mem_lat           = 2;
    bus.ma_i_dm_req   = 1'b1;
    bus.ma_i_dm_we    = 1'b1;
    bus.ma_i_dm_mask  = 4'b0011;
    bus.ma_i_dm_addr  = 32'h0000_0100;
    bus.ma_i_dm_wdata = 32'h0000_BEEF;
    @(negedge ma_clk);
    check("st_gnt", {62'd0, bus.ma_o_dm_gnt, bus.ma_o_if_gnt}, 64'b10);
    sb.push_back('{dm: 1'b1, data: 32'h0});
    cyc();
    bus.ma_i_dm_req   = 1'b0;
    bus.ma_i_dm_we    = 1'b0;
    bus.ma_i_dm_mask  = 4'hF;
    bus.ma_i_dm_addr  = 32'h0000_0FFF;
    bus.ma_i_dm_wdata = 32'h1234_5678;
    for (int c = 1; c <= 2; c++) begin
      if (c > 1) begin
        cyc();
        @(negedge ma_clk);
      end else begin
        @(negedge ma_clk);
      end
      check($sformatf("st_fields_c%0d", c),
            {26'd0, bus.ma_o_mem_req, bus.ma_o_mem_we, bus.ma_o_mem_mask, bus.ma_o_mem_wdata},
            {26'd0, 1'b1, 1'b1, 4'b0011, 32'h0000_BEEF});
      check($sformatf("st_addr_c%0d", c), {32'd0, bus.ma_o_mem_addr}, 64'h100);
      check($sformatf("st_stall_c%0d", c), {62'd0, bus.ma_o_dm_stall, bus.ma_o_dm_valid}, 64'b10);
    end
    cyc();
    @(negedge ma_clk);
    check("st_valid", {61'd0, bus.ma_o_dm_valid, bus.ma_o_dm_stall, bus.ma_o_mem_req}, 64'b100);
    check("st_rdata", {32'd0, bus.ma_o_dm_rdata}, 64'd0);

    // ---------- reset mid-transaction, late ack, stray ack ----------
    cyc();
    mem_en            = 1'b0;
    bus.ma_i_dm_req   = 1'b1;
    bus.ma_i_dm_we    = 1'b0;
    bus.ma_i_dm_addr  = 32'h0000_0300;
    @(negedge ma_clk);
    check("mr_gnt", {63'd0, bus.ma_o_dm_gnt}, 64'd1);
    cyc();
    bus.ma_i_dm_req = 1'b0;
    @(negedge ma_clk);
    check("mr_busy", {63'd0, bus.ma_o_mem_req}, 64'd1);
    cyc();
    ma_rst = 1'b1;
    @(negedge ma_clk);
    check("mr_rst_stall", {62'd0, bus.ma_o_dm_stall, bus.ma_o_dm_gnt}, 64'd0);
    cyc();
    ma_rst     = 1'b0;
    manual_ack = 1'b1;
    @(negedge ma_clk);
    check("mr_req_dropped", {62'd0, bus.ma_o_mem_req, bus.ma_o_dm_valid}, 64'd0);
    cyc();
    manual_ack = 1'b0;
    @(negedge ma_clk);
    check("mr_no_valid", {61'd0, bus.ma_o_dm_valid, bus.ma_o_if_valid, bus.ma_o_mem_req}, 64'd0);
    cyc();
    manual_ack = 1'b1;
    @(negedge ma_clk);
    check("stray_no_gnt", {62'd0, bus.ma_o_if_gnt, bus.ma_o_dm_gnt}, 64'd0);
    cyc();
    manual_ack = 1'b0;
    @(negedge ma_clk);
    check("stray_no_valid", {61'd0, bus.ma_o_dm_valid, bus.ma_o_if_valid, bus.ma_o_mem_req},
          64'd0);

    // ---------- back-to-back data loads ----------
    cyc();
    mem_en           = 1'b1;
    mem_lat          = 1;
    bus.ma_i_dm_req  = 1'b1;
    bus.ma_i_dm_addr = 32'h0000_0400;
    @(negedge ma_clk);
    check("b2b_gnt1", {63'd0, bus.ma_o_dm_gnt}, 64'd1);
    sb.push_back('{dm: 1'b1, data: mem_word(32'h0000_0400)});
    cyc();
    bus.ma_i_dm_req = 1'b0;
    @(negedge ma_clk);
    check("b2b_req1", {63'd0, bus.ma_o_mem_req}, 64'd1);
    cyc();
    bus.ma_i_dm_req  = 1'b1;
    bus.ma_i_dm_addr = 32'h0000_0404;
    @(negedge ma_clk);
    check("b2b_gnt2_with_valid1",
          {61'd0, bus.ma_o_dm_gnt, bus.ma_o_dm_valid, bus.ma_o_mem_req}, 64'b110);
    sb.push_back('{dm: 1'b1, data: mem_word(32'h0000_0404)});
    cyc();
    bus.ma_i_dm_req = 1'b0;
    @(negedge ma_clk);
    check("b2b_req2", {63'd0, bus.ma_o_mem_req}, 64'd1);
    check("b2b_addr2", {32'd0, bus.ma_o_mem_addr}, 64'h404);
    cyc();
    @(negedge ma_clk);
    check("b2b_valid2", {63'd0, bus.ma_o_dm_valid}, 64'd1);
    cyc();
    @(negedge ma_clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
